// File: rtl/dct_coef_serializer.sv
// dct_coef_serializer
//   Takes a complete 8x8 block of signed DCT coefficients in one handshake
//   and streams it out one coefficient per cycle, in JPEG zigzag order
//   (ZIGZAG = 1) or row-major raster order (ZIGZAG = 0). Two banks let the
//   upstream DCT deliver the next block while the current one drains.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both high. Valid never depends on ready, and both
//   ready and valid here come from registers only.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   blk_valid    blk_data holds a complete block
//   blk_ready    a bank is free (block accepted on blk_valid && blk_ready)
//   blk_data     block, element blk_data[c][r] (c = column, r = row)
//   coef_valid   coef_data / coef_idx / coef_row / coef_col / coef_last valid
//   coef_ready   downstream accepts the current coefficient
//   coef_data    current coefficient, unchanged copy of the stored element
//   coef_idx     output sequence position k (0..63)
//   coef_row     row r of the current coefficient
//   coef_col     column c of the current coefficient
//   coef_last    high on the final coefficient of a block (k == 63)
module dct_coef_serializer #(
  parameter int SIZE_IN = 12,
  parameter bit ZIGZAG  = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 blk_valid,
  output logic                                 blk_ready,
  input  logic signed [7:0][7:0][SIZE_IN-1:0]  blk_data,
  output logic                                 coef_valid,
  input  logic                                 coef_ready,
  output logic signed [SIZE_IN-1:0]            coef_data,
  output logic [5:0]                           coef_idx,
  output logic [2:0]                           coef_row,
  output logic [2:0]                           coef_col,
  output logic                                 coef_last
);

  // Complete control state in one struct so checkers can bind to it.
  // full[b] is the per-bank EMPTY(0)/FULL(1) state.
  typedef struct packed {
    logic [1:0] full;
    logic       wr_bank;
    logic       rd_bank;
    logic [5:0] k;
  } ser_state_t;

  ser_state_t state_q;
  ser_state_t state_d;

  // Coefficient storage: mem_q[bank][c][r]. Not reset; the full flags
  // decide whether a bank's contents mean anything.
  logic [1:0][7:0][7:0][SIZE_IN-1:0] mem_q;

  logic       accept;
  logic       pop;
  logic [5:0] pos;  // {r, c} of the coefficient at position k

  // Zigzag ROM: sequence position k -> raster position 8*r + c.
  function automatic logic [5:0] zigzag_pos(input logic [5:0] k);
    logic [5:0] p;
    case (k)
      6'd0:  p = 6'd0;   6'd1:  p = 6'd1;   6'd2:  p = 6'd8;   6'd3:  p = 6'd16;
      6'd4:  p = 6'd9;   6'd5:  p = 6'd2;   6'd6:  p = 6'd3;   6'd7:  p = 6'd10;
      6'd8:  p = 6'd17;  6'd9:  p = 6'd24;  6'd10: p = 6'd32;  6'd11: p = 6'd25;
      6'd12: p = 6'd18;  6'd13: p = 6'd11;  6'd14: p = 6'd4;   6'd15: p = 6'd5;
      6'd16: p = 6'd12;  6'd17: p = 6'd19;  6'd18: p = 6'd26;  6'd19: p = 6'd33;
      6'd20: p = 6'd40;  6'd21: p = 6'd48;  6'd22: p = 6'd41;  6'd23: p = 6'd34;
      6'd24: p = 6'd27;  6'd25: p = 6'd20;  6'd26: p = 6'd13;  6'd27: p = 6'd6;
      6'd28: p = 6'd7;   6'd29: p = 6'd14;  6'd30: p = 6'd21;  6'd31: p = 6'd28;
      6'd32: p = 6'd35;  6'd33: p = 6'd42;  6'd34: p = 6'd49;  6'd35: p = 6'd56;
      6'd36: p = 6'd57;  6'd37: p = 6'd50;  6'd38: p = 6'd43;  6'd39: p = 6'd36;
      6'd40: p = 6'd29;  6'd41: p = 6'd22;  6'd42: p = 6'd15;  6'd43: p = 6'd23;
      6'd44: p = 6'd30;  6'd45: p = 6'd37;  6'd46: p = 6'd44;  6'd47: p = 6'd51;
      6'd48: p = 6'd58;  6'd49: p = 6'd59;  6'd50: p = 6'd52;  6'd51: p = 6'd45;
      6'd52: p = 6'd38;  6'd53: p = 6'd31;  6'd54: p = 6'd39;  6'd55: p = 6'd46;
      6'd56: p = 6'd53;  6'd57: p = 6'd60;  6'd58: p = 6'd61;  6'd59: p = 6'd54;
      6'd60: p = 6'd47;  6'd61: p = 6'd55;  6'd62: p = 6'd62;  6'd63: p = 6'd63;
      default: p = k;
    endcase
    return p;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  // Block capture: the whole block lands in the write bank in one cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[state_q.wr_bank] <= blk_data;
    end
  end

  // Next-state logic. An accept only targets an empty bank and a pop only
  // drains a full one, so both may happen in the same cycle without
  // touching the same flag.
  always_comb begin
    accept  = blk_valid && !state_q.full[state_q.wr_bank];
    pop     = coef_ready && state_q.full[state_q.rd_bank];
    state_d = state_q;
    if (accept) begin
      state_d.full[state_q.wr_bank] = 1'b1;
      state_d.wr_bank               = ~state_q.wr_bank;
    end
    if (pop) begin
      if (state_q.k == 6'd63) begin
        state_d.full[state_q.rd_bank] = 1'b0;
        state_d.rd_bank               = ~state_q.rd_bank;
        state_d.k                     = 6'd0;
      end else begin
        state_d.k = state_q.k + 6'd1;
      end
    end
  end

  // Outputs: registered state and storage only, so they hold steady
  // through any stall.
  always_comb begin
    blk_ready  = !state_q.full[state_q.wr_bank];
    coef_valid = state_q.full[state_q.rd_bank];
    pos        = ZIGZAG ? zigzag_pos(state_q.k) : state_q.k;
    coef_row   = pos[5:3];
    coef_col   = pos[2:0];
    coef_idx   = state_q.k;
    coef_last  = coef_valid && (state_q.k == 6'd63);
    // Data is forced to zero while idle so stale bank contents never show.
    coef_data  = coef_valid ? mem_q[state_q.rd_bank][pos[2:0]][pos[5:3]] : '0;
  end

endmodule

// File: doc/dct_coef_serializer.md
Name: dct_coef_serializer

Overview:
- Sits at the output of the 2-D DCT second (column) stage.
- Accepts one complete 8x8 block of signed coefficients in a single valid/ready handshake.
- Streams the block out one coefficient per cycle, in JPEG zigzag order (or raster order), to the quantizer/entropy path.
- Double-buffered, so a full-rate DCT can hand over a new block while the previous one drains.

Parameters:
- SIZE_IN, 12: signed coefficient width; matches second-stage output width (stage SIZE 10 + 2).
- ZIGZAG, 1: 1 = JPEG zigzag output order; 0 = raster order (row-major).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- blk_valid  in  1  blk_data holds a complete block
- blk_ready  out  1  a buffer bank is free; block accepted when blk_valid && blk_ready
- blk_data  in  signed [SIZE_IN-1:0] [7:0][7:0]  coefficient block. First index = column c (horizontal frequency), second = row r; element blk_data[c][r].
- coef_valid  out  1  coef_data valid
- coef_ready  in  1  downstream accepts; transfer when coef_valid && coef_ready
- coef_data  out  signed [SIZE_IN-1:0]  current coefficient, bit-exact copy of the captured element
- coef_idx  out  6  output sequence position k, 0..63
- coef_row  out  3  r of current coefficient
- coef_col  out  3  c of current coefficient
- coef_last  out  1  high when k == 63

Behaviour:
- Storage:
  - Two banks of 64 x SIZE_IN.
  - Per-bank full flags, wr_bank and rd_bank pointers, 6-bit read counter k.
- Reset:
  - All flags clear, both pointers 0, k = 0.
  - coef_valid = 0, blk_ready = 1.
  - coef_idx/row/col/data = 0, coef_last = 0.
  - Reset mid-stream discards both banks and any partial drain; the next output after reset is k = 0 of a newly accepted block.
- blk_ready = !full[wr_bank]. It is a function of registers only; there is no combinational path from coef_ready or blk_valid.
- On accept:
  - All 64 elements are written to bank wr_bank.
  - full[wr_bank] is set and wr_bank toggles.
  - blk_data need not be held after the accept cycle.
- coef_valid = full[rd_bank].
- Latency: a block accepted at cycle T with the read side idle presents k = 0 with coef_valid = 1 at cycle T+1.
- Read state per bank: EMPTY -> FULL on accept. FULL -> EMPTY on the handshake with k == 63; on that same edge, rd_bank toggles and k returns to 0.
- Other handshakes: k increments by 1.
- Order mapping (k -> (r, c)):
  - ZIGZAG = 1: standard JPEG table (row, col): k0 (0,0), k1 (0,1), k2 (1,0), k3 (2,0), k4 (1,1), k5 (0,2), ..., k61 (6,7), k62 (7,6), k63 (7,7).
  - ZIGZAG = 0: r = k[5:3], c = k[2:0].
  - The table is a constant ROM/case indexed by k.
- coef_data = bank[rd_bank][c][r] for the mapped (r, c).
- coef_idx/row/col/data/last are functions of registered state only. They hold stable while coef_valid && !coef_ready.
- Throughput:
  - With back-to-back blocks and coef_ready = 1, output is gapless: 64 coefficients per 64 cycles.
  - k0 of the next bank follows k63 of the previous bank on the next cycle when that bank is already full.
- Simultaneous events:
  - An accept into one bank and a final pop from the other bank in the same cycle are both performed.
  - When both banks are full, blk_ready stays 0 in the cycle of the final pop and rises on the next cycle.
- A pop when the bank is empty cannot occur (coef_valid = 0). blk_valid while blk_ready = 0 is ignored; no capture occurs.
- No arithmetic: values pass unchanged, sign preserved; no saturation or rounding.

Test Plan:
- Single block, blk_data[c][r] = 8r + c, ZIGZAG = 1, coef_ready = 1:
  - coef_valid rises 1 cycle after accept.
  - coef_data sequence is 0, 1, 8, 16, 9, 2, ..., 55, 62, 63.
  - coef_last is high only on the value 63.
  - k0 has coef_row = 0, coef_col = 0; k63 has coef_row = 7, coef_col = 7.
- Three back-to-back blocks, each a constant fill 100/200/300, coef_ready = 1:
  - 192 consecutive valid cycles with no bubble.
  - Values switch exactly after each coef_last.
  - blk_ready is low when both banks are full.
- Backpressure: toggle coef_ready pseudo-randomly:
  - No duplicate or skipped k.
  - coef_data/idx remain stable during every stalled cycle.
- Fill both banks with coef_ready = 0:
  - blk_ready = 0; a third blk_valid is not captured.
  - After the 64th pop of bank 0, blk_ready returns to 1 one cycle later.
- Negative values (all elements -2048, and alternating ±1) at SIZE_IN = 12:
  - Output is bit-exact.
  - ZIGZAG = 0 build with the same input as the first scenario yields 0, 1, 2, ..., 63 in sequence.
- Assert rst at k = 30 of block 1 with block 2 buffered:
  - Next cycle: coef_valid = 0, blk_ready = 1.
  - A fresh block then streams from k = 0.
